// File: rtl/fp_pkg.sv
// ============================================================================
//  fp_pkg
//  Shared floating-point format constants, converter FSM states and rounding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FW_SP   = 23;
    localparam int EW_SP   = 8;
    localparam int BIAS_SP = 127;
    localparam int FW_DP   = 52;
    localparam int EW_DP   = 11;
    localparam int BIAS_DP = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } cvt_state_t;

    function automatic int frac_width(input int w);
        return (w == 64) ? FW_DP : FW_SP;
    endfunction

    function automatic int exp_width(input int w);
        return (w == 64) ? EW_DP : EW_SP;
    endfunction

    function automatic int exp_bias(input int w);
        return (w == 64) ? BIAS_DP : BIAS_SP;
    endfunction

    // Round-to-nearest-even increment decision.
    function automatic logic rne_round_inc(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_leading_zeros.sv
// ============================================================================
//  count_leading_zeros
//  Combinational leading-zero count of a 2**LG_N-bit word (all-zero gives 0).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module count_leading_zeros #(
    parameter int LG_N = 6
) (
    input  logic [(1<<LG_N)-1:0] value,
    output logic [LG_N-1:0]      count
);

    localparam int N = 1 << LG_N;

    // Highest set bit wins since it is visited last.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            if (value[i]) count = LG_N'(N - 1 - i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_to_fp.sv
// ============================================================================
//  int_to_fp
//  Multi-cycle 32/64-bit integer to binary32/binary64 converter with RNE rounding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module int_to_fp
    import fp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic         is_64b_src,
    input  logic [63:0]  src,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y,
    output logic         inexact
);

    localparam int FW   = frac_width(W);
    localparam int EW   = exp_width(W);
    localparam int BIAS = exp_bias(W);

    cvt_state_t  state;
    logic        sign;
    logic [63:0] mag;
    logic [6:0]  exp_u;

    logic [63:0]   ext;
    logic          ext_neg;
    logic [5:0]    lz;
    logic [FW:0]   kept;
    logic          guard;
    logic          sticky;
    logic [FW+1:0] sum;
    logic          is_zero;
    logic [EW-1:0] exp_b;

    assign ext = is_64b_src ? src
               : (is_signed ? {{32{src[31]}}, src[31:0]} : {32'd0, src[31:0]});
    assign ext_neg = is_signed & ext[63];

    count_leading_zeros #(.LG_N(6)) u_clz (
        .value (mag),
        .count (lz)
    );

    // Rounding operates on the normalized magnitude held in mag during ROUND.
    always_comb begin
        kept    = mag[63 -: FW+1];
        guard   = mag[62-FW];
        sticky  = |mag[61-FW:0];
        sum     = {1'b0, kept} + (FW+2)'(rne_round_inc(kept[0], guard, sticky));
        is_zero = ~(sum[FW+1] | sum[FW]);
        exp_b   = EW'(exp_u) + EW'(BIAS) + EW'(sum[FW+1]);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            exp_u   <= '0;
            y       <= '0;
            inexact <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= ext_neg;
                        mag   <= ext_neg ? -ext : ext;
                        state <= NORM;
                    end
                end
                NORM: begin
                    mag   <= mag << lz;
                    exp_u <= 7'd63 - {1'b0, lz};
                    state <= ROUND;
                end
                ROUND: begin
                    // On carry-out the fraction field of sum is already all zeros.
                    y       <= is_zero ? '0 : {sign, exp_b, sum[FW-1:0]};
                    inexact <= guard | sticky;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
